// File: rtl/riscv_div_pkg.sv
// Shared opcode encodings and sequencer state type for the serial divide path.
package riscv_div_pkg;

    localparam logic [1:0] DIV_UDIV = 2'd0;
    localparam logic [1:0] DIV_DIV  = 2'd1;
    localparam logic [1:0] DIV_UREM = 2'd2;
    localparam logic [1:0] DIV_REM  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_RESP  = 3'd5
    } div_seq_state_e;

endpackage

// File: rtl/riscv_div_lzc.sv
// Leading-zero (or leading-one, with Invert_SI) counter; all-zero input counts C_WIDTH.
module riscv_div_lzc #(
    parameter int unsigned C_WIDTH     = 32,
    parameter int unsigned C_LOG_WIDTH = 6
) (
    input  logic [C_WIDTH-1:0]     Vec_DI,
    input  logic                   Invert_SI,
    output logic [C_LOG_WIDTH-1:0] Cnt_DO
);

    logic [C_WIDTH-1:0] pattern;

    // Scan upwards so the highest set bit determines the count.
    always_comb begin
        pattern = Vec_DI ^ {C_WIDTH{Invert_SI}};
        Cnt_DO  = C_LOG_WIDTH'(C_WIDTH);
        for (int i = 0; i < int'(C_WIDTH); i++) begin
            if (pattern[i]) begin
                Cnt_DO = C_LOG_WIDTH'(C_WIDTH - 32'(i) - 32'd1);
            end
        end
    end

endmodule

// File: rtl/riscv_div_seq.sv
// Front-end sequencer for the serial divider: operand prep, issue, result capture,
// flush handling and a one-entry cache of the last completed request.
module riscv_div_seq
    import riscv_div_pkg::*;
#(
    parameter int unsigned C_WIDTH     = 32,
    parameter int unsigned C_LOG_WIDTH = 6
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RI,
    input  logic                   ReqVld_SI,
    output logic                   ReqRdy_SO,
    input  logic [C_WIDTH-1:0]     ReqOpA_DI,
    input  logic [C_WIDTH-1:0]     ReqOpB_DI,
    input  logic [1:0]             ReqOpCode_SI,
    input  logic                   Flush_SI,
    output logic [C_WIDTH-1:0]     DivOpA_DO,
    output logic [C_WIDTH-1:0]     DivOpB_DO,
    output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
    output logic                   DivOpBIsZero_SO,
    output logic                   DivOpBSign_SO,
    output logic [1:0]             DivOpCode_SO,
    output logic                   DivInVld_SO,
    input  logic                   DivOutVld_SI,
    output logic                   DivOutRdy_SO,
    input  logic [C_WIDTH-1:0]     DivRes_DI,
    output logic                   RspVld_SO,
    input  logic                   RspRdy_SI,
    output logic [C_WIDTH-1:0]     RspRes_DO
);

    div_seq_state_e stateQ, stateD;

    logic [C_WIDTH-1:0]     opAQ, opBQ;
    logic [1:0]             opCodeQ;
    logic                   cacheVldQ;
    logic [C_WIDTH-1:0]     cacheOpAQ, cacheOpBQ, cacheResQ;
    logic [1:0]             cacheOpCodeQ;

    logic                   reqAccept, cacheHit, capture;
    logic                   signC;
    logic [C_LOG_WIDTH-1:0] shiftC;

    assign cacheHit = cacheVldQ && (ReqOpA_DI == cacheOpAQ) && (ReqOpB_DI == cacheOpBQ)
                      && (ReqOpCode_SI == cacheOpCodeQ);

    // Negative signed divisors normalise on leading ones instead of leading zeros.
    assign signC = opCodeQ[0] & opBQ[C_WIDTH-1];

    riscv_div_lzc #(
        .C_WIDTH     (C_WIDTH),
        .C_LOG_WIDTH (C_LOG_WIDTH)
    ) i_lzc (
        .Vec_DI    (opBQ),
        .Invert_SI (signC),
        .Cnt_DO    (shiftC)
    );

    // Next-state and handshake decode.
    always_comb begin
        stateD       = stateQ;
        ReqRdy_SO    = 1'b0;
        DivInVld_SO  = 1'b0;
        DivOutRdy_SO = 1'b0;
        RspVld_SO    = 1'b0;
        reqAccept    = 1'b0;
        capture      = 1'b0;
        unique case (stateQ)
            ST_IDLE: begin
                ReqRdy_SO = ~Flush_SI;
                if (ReqVld_SI && !Flush_SI) begin
                    reqAccept = 1'b1;
                    stateD    = cacheHit ? ST_RESP : ST_PREP;
                end
            end
            ST_PREP: begin
                stateD = Flush_SI ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: begin
                DivInVld_SO = ~Flush_SI;
                stateD      = Flush_SI ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                DivOutRdy_SO = 1'b1;
                if (Flush_SI) begin
                    stateD = ST_DRAIN;
                end else if (DivOutVld_SI) begin
                    capture = 1'b1;
                    stateD  = ST_RESP;
                end
            end
            ST_DRAIN: begin
                DivOutRdy_SO = 1'b1;
                if (DivOutVld_SI) begin
                    stateD = ST_IDLE;
                end
            end
            ST_RESP: begin
                RspVld_SO = 1'b1;
                if (RspRdy_SI || Flush_SI) begin
                    stateD = ST_IDLE;
                end
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    // State, operand, divider-input, response and cache registers.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            stateQ          <= ST_IDLE;
            opAQ            <= '0;
            opBQ            <= '0;
            opCodeQ         <= '0;
            DivOpA_DO       <= '0;
            DivOpB_DO       <= '0;
            DivOpBShift_DO  <= '0;
            DivOpBIsZero_SO <= 1'b0;
            DivOpBSign_SO   <= 1'b0;
            DivOpCode_SO    <= '0;
            RspRes_DO       <= '0;
            cacheVldQ       <= 1'b0;
            cacheOpAQ       <= '0;
            cacheOpBQ       <= '0;
            cacheOpCodeQ    <= '0;
            cacheResQ       <= '0;
        end else begin
            stateQ <= stateD;
            if (reqAccept) begin
                opAQ    <= ReqOpA_DI;
                opBQ    <= ReqOpB_DI;
                opCodeQ <= ReqOpCode_SI;
                if (cacheHit) begin
                    RspRes_DO <= cacheResQ;
                end
            end
            if (stateQ == ST_PREP) begin
                DivOpA_DO       <= opAQ;
                DivOpB_DO       <= opBQ << shiftC;
                DivOpBShift_DO  <= shiftC;
                DivOpBIsZero_SO <= (opBQ == '0);
                DivOpBSign_SO   <= signC;
                DivOpCode_SO    <= opCodeQ;
            end
            if (capture) begin
                RspRes_DO    <= DivRes_DI;
                cacheVldQ    <= 1'b1;
                cacheOpAQ    <= opAQ;
                cacheOpBQ    <= opBQ;
                cacheOpCodeQ <= opCodeQ;
                cacheResQ    <= DivRes_DI;
            end
        end
    end

endmodule

// File: tb/tb_riscv_div_seq.sv
// Self-checking bench for riscv_div_seq with a cycle-level model of the serial divider.
module tb_riscv_div_seq;
    import riscv_div_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned LW = 6;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          ReqVld = 1'b0, ReqRdy;
    logic [W-1:0]  ReqOpA = '0, ReqOpB = '0;
    logic [1:0]    ReqOpCode = '0;
    logic          Flush = 1'b0;
    logic [W-1:0]  DivOpA, DivOpB;
    logic [LW-1:0] DivOpBShift;
    logic          DivOpBIsZero, DivOpBSign;
    logic [1:0]    DivOpCode;
    logic          DivInVld, DivOutVld, DivOutRdy;
    logic [W-1:0]  DivRes;
    logic          RspVld, RspRdy = 1'b0;
    logic [W-1:0]  RspRes;

    int nAssert = 0;
    int nFail   = 0;

    riscv_div_seq #(.C_WIDTH(W), .C_LOG_WIDTH(LW)) dut (
        .Clk_CI          (Clk),
        .Rst_RI          (Rst),
        .ReqVld_SI       (ReqVld),
        .ReqRdy_SO       (ReqRdy),
        .ReqOpA_DI       (ReqOpA),
        .ReqOpB_DI       (ReqOpB),
        .ReqOpCode_SI    (ReqOpCode),
        .Flush_SI        (Flush),
        .DivOpA_DO       (DivOpA),
        .DivOpB_DO       (DivOpB),
        .DivOpBShift_DO  (DivOpBShift),
        .DivOpBIsZero_SO (DivOpBIsZero),
        .DivOpBSign_SO   (DivOpBSign),
        .DivOpCode_SO    (DivOpCode),
        .DivInVld_SO     (DivInVld),
        .DivOutVld_SI    (DivOutVld),
        .DivOutRdy_SO    (DivOutRdy),
        .DivRes_DI       (DivRes),
        .RspVld_SO       (RspVld),
        .RspRdy_SI       (RspRdy),
        .RspRes_DO       (RspRes)
    );

    always #5 Clk = ~Clk;

    // Golden RISC-V divide/remainder semantics.
    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        logic signed [W-1:0] sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            DIV_UDIV: return (b == '0) ? 32'hFFFF_FFFF : a / b;
            DIV_DIV:  return (b == '0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            DIV_UREM: return (b == '0) ? a : a % b;
            default:  return (b == '0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
        endcase
    endfunction

    // Divider model: IDLE (OutVld high), DIVIDE for Shift+1 cycles, FINISH until OutRdy.
    logic [W-1:0] curA = '0, curB = '0;
    logic [1:0]   curOp = '0;
    logic [1:0]   dState = 2'd0;
    int           dCnt = 0;
    int           dHs = 0;
    int           issueCnt = 0;
    logic [W-1:0] dRes = '0;

    assign DivOutVld = (dState != 2'd1);
    assign DivRes    = dRes;

    always @(posedge Clk) begin
        if (Rst) begin
            dState <= 2'd0;
        end else begin
            if (DivInVld) issueCnt <= issueCnt + 1;
            case (dState)
                2'd0: if (DivInVld) begin
                    dRes   <= ref_div(curA, curB, curOp);
                    dCnt   <= int'(DivOpBShift);
                    dState <= 2'd1;
                end
                2'd1: if (dCnt == 0) dState <= 2'd2; else dCnt <= dCnt - 1;
                default: if (DivOutRdy) begin
                    dState <= 2'd0;
                    dHs    <= dHs + 1;
                end
            endcase
        end
    end

    logic [W-1:0] expQ[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_reqrdy"}, 32'(ReqRdy), 32'd1);
        check({tag, "_invld"},  32'(DivInVld), 32'd0);
        check({tag, "_outrdy"}, 32'(DivOutRdy), 32'd0);
        check({tag, "_rspvld"}, 32'(RspVld), 32'd0);
        check({tag, "_rspres"}, RspRes, 32'd0);
        check({tag, "_opa"},    DivOpA, 32'd0);
        check({tag, "_opb"},    DivOpB, 32'd0);
        check({tag, "_flags"},  {22'd0, DivOpBShift, DivOpBIsZero, DivOpBSign, DivOpCode}, 32'd0);
    endtask

    // Issue one request, check divider inputs, latency, issue count, hold and handshake.
    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                          input logic [W-1:0] expRes, input int expShift, input int expLat,
                          input int holdCyc);
        int lat, iss0;
        logic [W-1:0] exp;
        curA = a; curB = b; curOp = op;
        expQ.push_back(expRes);
        iss0 = issueCnt;
        check("req_rdy_idle", 32'(ReqRdy), 32'd1);
        ReqVld = 1'b1; ReqOpA = a; ReqOpB = b; ReqOpCode = op;
        tick();
        ReqVld = 1'b0;
        lat = 1;
        while (!RspVld && lat < 200) begin
            if (DivInVld) begin
                check("issue_opa",   DivOpA, a);
                check("issue_opb",   DivOpB, b << expShift);
                check("issue_shift", 32'(DivOpBShift), 32'(expShift));
                check("issue_zero",  32'(DivOpBIsZero), 32'(b == '0));
                check("issue_sign",  32'(DivOpBSign), 32'(op[0] & b[W-1]));
                check("issue_op",    32'(DivOpCode), 32'(op));
            end
            tick();
            lat++;
        end
        exp = expQ.pop_front();
        if (!RspVld) begin
            check("rsp_timeout", 32'(RspVld), 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(expLat));
        check("issue_cnt", 32'(issueCnt - iss0), (expLat == 1) ? 32'd0 : 32'd1);
        for (int i = 0; i < holdCyc; i++) begin
            tick();
            check("hold_vld", 32'(RspVld), 32'd1);
            check("hold_res", RspRes, exp);
            check("hold_reqrdy", 32'(ReqRdy), 32'd0);
        end
        check("rsp_res", RspRes, exp);
        RspRdy = 1'b1;
        tick();
        RspRdy = 1'b0;
        check("post_rsp_vld", 32'(RspVld), 32'd0);
        check("post_rsp_reqrdy", 32'(ReqRdy), 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] res;
        int           shift;
        int           lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int hs0, cyc, badRsp, badRdy, bound;

        vecs[0] = '{32'd100,       32'd7,         DIV_UDIV, 32'd14,        29, 34};
        vecs[1] = '{32'hFFFF_FF9C, 32'd7,         DIV_REM,  32'hFFFF_FFFE, 29, 34};
        vecs[2] = '{32'hFFFF_FF9C, 32'd7,         DIV_REM,  32'hFFFF_FFFE, 29, 1};
        vecs[3] = '{32'd5,         32'd0,         DIV_UDIV, 32'hFFFF_FFFF, 32, 37};
        vecs[4] = '{32'd5,         32'd0,         DIV_UREM, 32'd5,         32, 37};
        vecs[5] = '{32'hFFFF_FFF9, 32'd2,         DIV_DIV,  32'hFFFF_FFFD, 30, 35};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, DIV_UDIV, 32'd1,         0,  5};
        vecs[7] = '{32'd7,         32'hFFFF_FFFE, DIV_REM,  32'd1,         31, 36};
        vecs[8] = '{32'd100,       32'd7,         DIV_UREM, 32'd2,         29, 34};

        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        tick();
        check_idle_zero("reset");

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].shift, vecs[i].lat, 0);
        end

        // Signed overflow with a stalled consumer, then an exact repeat from the cache.
        do_req(32'h8000_0000, 32'hFFFF_FFFF, DIV_DIV, 32'h8000_0000, 32, 37, 10);
        do_req(32'h8000_0000, 32'hFFFF_FFFF, DIV_DIV, 32'h8000_0000, 32, 1, 0);

        // Flush three cycles into WAIT: result is drained, never responded.
        curA = 32'hFFFF_FFFF; curB = 32'd1; curOp = DIV_UDIV;
        ReqVld = 1'b1; ReqOpA = curA; ReqOpB = curB; ReqOpCode = curOp;
        tick();
        ReqVld = 1'b0;
        bound = 0;
        while (!DivInVld && bound < 10) begin
            tick();
            bound++;
        end
        check("flush_issue_seen", 32'(DivInVld), 32'd1);
        repeat (4) tick();
        hs0 = dHs;
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        cyc = 0; badRsp = 0; badRdy = 0;
        while (dHs == hs0 && cyc < 100) begin
            if (RspVld) badRsp++;
            if (ReqRdy) badRdy++;
            tick();
            cyc++;
        end
        check("drain_done", 32'(dHs != hs0), 32'd1);
        check("drain_no_rsp", 32'(badRsp), 32'd0);
        check("drain_reqrdy_low", 32'(badRdy), 32'd0);
        check("drain_reqrdy_back", 32'(ReqRdy), 32'd1);
        check("drain_rspvld", 32'(RspVld), 32'd0);
        do_req(32'hFFFF_FFFF, 32'd1, DIV_UDIV, 32'hFFFF_FFFF, 31, 36, 0);

        // Reset during DIVIDE invalidates the cache.
        do_req(32'd1000, 32'd3, DIV_UDIV, 32'd333, 30, 35, 0);
        curA = 32'd2000; curB = 32'd3; curOp = DIV_UDIV;
        ReqVld = 1'b1; ReqOpA = curA; ReqOpB = curB; ReqOpCode = curOp;
        tick();
        ReqVld = 1'b0;
        bound = 0;
        while (!DivInVld && bound < 10) begin
            tick();
            bound++;
        end
        repeat (3) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_idle_zero("midrst");
        do_req(32'd1000, 32'd3, DIV_UDIV, 32'd333, 30, 35, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/riscv_div_seq.md
# riscv_div_seq

Front-end sequencer that feeds the serial divider `riscv_alu_div` and consumes its result.
- Accepts a DIV/DIVU/REM/REMU request from EX over a valid/ready handshake and registers the operands.
- Computes the normalisation shift, the shifted divisor and the flags, issues a single-cycle `InVld` to the divider, then waits for its `FINISH` state.
- Captures the result and holds it for writeback until accepted.
- Handles flush and answers an exact repeat of the last completed request from a one-entry result cache.

## Interface
Parameters:
- `C_WIDTH`, 32, operand/result width
- `C_LOG_WIDTH`, 6, shift-count width; equals $clog2(C_WIDTH+1)

Ports:
- `Clk_CI` in 1: clock; one clock domain.
- `Rst_RI` in 1: reset, synchronous, active-high. The top level drives the divider's `Rst_RBI` from `~Rst_RI`.
- `ReqVld_SI` in 1: request valid.
- `ReqRdy_SO` out 1: request ready.
- `ReqOpA_DI` in C_WIDTH: dividend.
- `ReqOpB_DI` in C_WIDTH: divisor.
- `ReqOpCode_SI` in 2: 0 udiv, 1 div, 2 urem, 3 rem.
- `Flush_SI` in 1: kill the in-flight operation.
- `DivOpA_DO` out C_WIDTH: dividend to the divider.
- `DivOpB_DO` out C_WIDTH: shifted divisor to the divider.
- `DivOpBShift_DO` out C_LOG_WIDTH: shift count to the divider.
- `DivOpBIsZero_SO` out 1: divisor-is-zero flag.
- `DivOpBSign_SO` out 1: divisor sign flag.
- `DivOpCode_SO` out 2: opcode to the divider.
- `DivInVld_SO` out 1: issue strobe.
- `DivOutVld_SI` in 1: divider output valid.
- `DivOutRdy_SO` out 1: divider output ready.
- `DivRes_DI` in C_WIDTH: divider result.
- `RspVld_SO` out 1: response valid.
- `RspRdy_SI` in 1: response ready.
- `RspRes_DO` out C_WIDTH: response data.

Reset values:
- All outputs are 0, except `ReqRdy_SO` = 1 (IDLE).
- Cache valid bit = 0.

## Operation
States: IDLE, PREP, ISSUE, WAIT, DRAIN, RESP.

- **IDLE:** `ReqRdy_SO` = ~`Flush_SI`. On acceptance, register A, B and OpCode.
  - Cache hit (cache valid and A, B, OpCode all equal the stored values): load the stored result and go to RESP.
  - Otherwise go to PREP.
- **PREP:** compute and register the divider inputs, then go to ISSUE.
  - `Sign` = OpCode[0] & B[msb].
  - `Shift` = Sign ? leading-ones(B) : leading-zeros(B). Range 0..C_WIDTH.
  - `DivOpB` = B << Shift. A shift of C_WIDTH gives 0.
  - `IsZero` = (B == 0).
  - Flush goes to IDLE.
- **ISSUE:** drive `DivInVld_SO` = 1 for exactly one cycle, then go to WAIT.
  - The divider is guaranteed idle here, because the sequencer never issues while a divide is outstanding.
  - Flush: suppress `InVld` and go to IDLE.
- **WAIT:** `DivOutRdy_SO` = 1.
  - When `DivOutVld_SI` = 1: capture `DivRes_DI` into the response register and the cache (A, B, OpCode, result, valid = 1), then go to RESP.
  - The divider's IDLE-state `OutVld` is never sampled: WAIT is only entered the cycle after issue, when the divider is already in DIVIDE.
  - Flush goes to DRAIN.
- **DRAIN:** `DivOutRdy_SO` = 1.
  - On `DivOutVld_SI`: discard the result, leave the cache unchanged, go to IDLE.
  - A flush while in DRAIN has no further effect.
- **RESP:** `RspVld_SO` = 1. `RspRes_DO` is held stable until `RspRdy_SI`, then go to IDLE.
  - Flush drops the response and goes to IDLE. The cache entry captured in WAIT stays valid.

Boundary rules:
- Flush and `RspRdy_SI` in the same RESP cycle: the response is consumed. This counts as the handshake; go to IDLE.
- Division by zero: issued normally. The divider's result is passed through unmodified, e.g. udiv x/0 = all-ones, rem x/0 = x.
- Signed overflow (0x80000000 / −1): passed through unmodified.
- Reset mid-operation: the sequencer returns to IDLE and the cache is invalidated. The divider is reset by the same reset.

## Timing
- Accept at cycle t (miss): PREP t+1, ISSUE t+2, divider DIVIDE t+3..t+3+Shift, WAIT captures at t+4+Shift.
- **Miss latency:** `RspVld_SO` rises at t+5+Shift.
- **Hit latency:** `RspVld_SO` rises at t+1.
- **Throughput:** the next request is accepted in the cycle after the response handshake.

## Structure
- Package `riscv_div_pkg`:
  - opcode constants (DIV_UDIV = 0, DIV_DIV = 1, DIV_UREM = 2, DIV_REM = 3);
  - state enum `div_seq_state_e`.
- Sub-module `riscv_div_lzc` (combinational):
  - inputs: C_WIDTH vector, invert bit;
  - output: leading-zero count of the input, XORed with the invert bit, in C_LOG_WIDTH bits;
  - count = C_WIDTH for an all-zero pattern.
- Instantiated once in PREP. The sequencer does not instantiate the divider; both are wired side by side in the ALU.

## Test plan
- udiv 100/7 → PREP drives Shift = 29, `DivOpB` = 0xE0000000; `RspRes` = 14 at t+34.
- rem −100/7 (0xFFFFFF9C, 0x00000007, OpCode 3) → `RspRes` = 0xFFFFFFFE (−2). Immediate repeat → hit, `RspRes` = 0xFFFFFFFE at t+1, and `DivInVld` stays 0.
- divu 5/0 → IsZero = 1, Shift = 32, `DivOpB` = 0; `RspRes` = 0xFFFFFFFF. remu 5/0 → 5.
- Flush asserted 3 cycles into WAIT for 0xFFFFFFFF/1 → DRAIN, no `RspVld`. `ReqRdy` returns only after the divider's FINISH handshake. Same request afterwards is a miss with full latency.
- `RspRdy` held low 10 cycles on div 0x80000000/0xFFFFFFFF → `RspVld`/`RspRes` = 0x80000000 stable throughout; `ReqRdy` = 0 until the handshake.
- `Rst_RI` pulsed during divider DIVIDE → next cycle IDLE, `ReqRdy` = 1, all outputs 0. A following request with identical operands is a miss.
